jt49_bus_master: RTL

- Register-bus initiator for the jt49 PSG core. It turns a queued stream of register read and write commands into cs_n/wr_n/addr/data cycles on the PSG's 4-bit register port.
- Timing guarantees the PSG's write-edge detector (envelope restart on reg 0xD) always fires.
- Read data from the PSG is returned on a pulse-qualified response port.
- Sits between a CPU/player/sequencer and jt49, in the same clk domain.

---
 rtl/jt49_bus_pkg.sv | 34 +++
 rtl/jt49_cmd_fifo.sv | 66 ++++++
 rtl/jt49_bus_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jt49_bus_pkg.sv
// Shared types for the jt49 register-bus initiator.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package jt49_bus_pkg;

  localparam int CMD_W      = 13;
  localparam int CMD_RD_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  // Packed field order yields rd at bit 12, addr at 11:8, data at 7:0.
  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic rd, input logic [3:0] addr,
                                                 input logic [7:0] data);
    cmd_t c;
    c.rd   = rd;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

endpackage

// File: rtl/jt49_cmd_fifo.sv
// Synchronous command FIFO, 2**AW entries of W bits, head visible combinationally.
// Latency: an entry pushed at edge N can be popped at edge N+1.
// Backpressure: full_o is registered; pushes while full and pops while empty are ignored.
module jt49_cmd_fifo #(
  parameter int AW = 3,
  parameter int W  = 13
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push   = push_i && !full_q;
  assign do_pop    = pop_i && (level_q != '0);
  assign pop_dat_o = mem_q[rptr_q];
  assign full_o    = full_q;
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Pointers, occupancy and a registered full flag; reset discards all entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_MAX);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/jt49_bus_master.sv
// Turns queued PSG register read/write commands into cs_n/wr_n/addr/data bus cycles.
// Latency: cs_n falls two edges after a command enters an empty FIFO; read data returns SETUP+2 cycles after cs_n falls.
// Backpressure: cmd_ready drops while the command FIFO is full.
module jt49_bus_master
  import jt49_bus_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int SETUP   = 2,
  parameter int STROBE  = 2,
  parameter int HOLD    = 1,
  parameter int CW      = 4
) (
  input  logic               rst_n,
  input  logic               clk,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_rd,
  input  logic [3:0]         cmd_addr,
  input  logic [7:0]         cmd_data,
  output logic [FIFO_AW:0]   cmd_level,
  output logic               busy,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic [3:0]         bus_addr,
  output logic               bus_cs_n,
  output logic               bus_wr_n,
  output logic [7:0]         bus_dout,
  input  logic [7:0]         bus_din
);

  if (FIFO_AW < 1 || SETUP < 1 || STROBE < 1 || HOLD < 1) begin : g_bad_min
    $error("jt49_bus_master: FIFO_AW, SETUP, STROBE and HOLD must each be at least 1");
  end
  if ((SETUP - 1) >= (1 << CW) || (STROBE - 1) >= (1 << CW) || (HOLD - 1) >= (1 << CW)) begin : g_bad_cw
    $error("jt49_bus_master: CW too narrow for the phase lengths");
  end

  // Counter holds remaining cycles minus one; zero means the phase ends this cycle.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  cmd_t            cmd_q, cmd_d, head;
  logic [CMD_W-1:0] head_bits, push_bits;
  logic            fifo_full, fifo_empty, push, pop;

  logic            cs_n_q, wr_n_q, samp_q, pend_q, rd_valid_q;
  logic [3:0]      addr_q;
  logic [7:0]      dout_q, rd_data_q;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign push_bits = pack_cmd(cmd_rd, cmd_addr, cmd_data);
  assign head      = cmd_t'(head_bits);
  assign busy      = (state_q != ST_IDLE) || (cmd_level != '0);

  assign bus_cs_n  = cs_n_q;
  assign bus_wr_n  = wr_n_q;
  assign bus_addr  = addr_q;
  assign bus_dout  = dout_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  jt49_cmd_fifo #(.AW(FIFO_AW), .W(CMD_W)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (push),
    .push_dat_i (push_bits),
    .pop_i      (pop),
    .pop_dat_o  (head_bits),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (cmd_level)
  );

  // Next-state: phase sequencing, counter reload on every state entry, FIFO pop in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    cmd_d   = cmd_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = head;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          if (cmd_q.rd) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LD;
          end
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, phase counter and the command being executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // Bus pins registered from the current state, so every bus phase lags its state by one
  // edge and phase lengths carry over unchanged; read data is captured at the end of the
  // bus SAMPLE cycle and flagged valid on the cycle after the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= '0;
      dout_q     <= '0;
      samp_q     <= 1'b0;
      pend_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cs_n_q <= !((state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                  (state_q == ST_HOLD)  || (state_q == ST_SAMPLE));
      wr_n_q <= (state_q != ST_STROBE);
      if (state_q == ST_SETUP) begin
        addr_q <= cmd_q.addr;
        dout_q <= cmd_q.data;
      end
      samp_q <= (state_q == ST_SAMPLE);
      if (samp_q) rd_data_q <= bus_din;
      pend_q     <= samp_q;
      rd_valid_q <= pend_q;
    end
  end

endmodule
